// File: rtl/egg_timer_ctrl.sv
// Egg-timer controller: key edge detection, set/run/pause mode FSM, 1 s tick
// prescaler, countdown datapath and bounded alarm flash with display blanking.
module egg_timer_ctrl #(
    parameter int TICK_DIV    = 50000000,
    parameter int MIN_W       = 7,
    parameter int MIN_MAX     = 99,
    parameter int FLASH_HALF  = 25000000,
    parameter int FLASH_COUNT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key,
    output logic [2:0]       state,
    output logic [MIN_W-1:0] min_val,
    output logic [5:0]       sec_val,
    output logic             alarm,
    output logic             blank
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int CW = (FLASH_COUNT > 0) ? $clog2(FLASH_COUNT + 1) : 1;
    localparam logic [PW-1:0]    PT = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0]    HT = FW'(FLASH_HALF - 1);
    localparam logic [CW-1:0]    FC = CW'(FLASH_COUNT);
    localparam logic [MIN_W-1:0] MM = MIN_W'(MIN_MAX);

    typedef enum logic [2:0] {
        SET_SEC   = 3'd0,
        SET_MIN   = 3'd1,
        RUN       = 3'd2,
        READY     = 3'd3,
        FLASH_ON  = 3'd5,
        FLASH_OFF = 3'd6,
        PAUSE     = 3'd7
    } st_t;

    st_t             st, st_n;
    logic [MIN_W-1:0] min_n;
    logic [5:0]      sec_n;
    logic [PW-1:0]   pr, pr_n;
    logic [FW-1:0]   hc, hc_n;
    logic [CW-1:0]   pc, pc_n;
    // key[0] is level-sensitive, so only the edge-triggered keys keep history
    logic [3:1]      key_q;
    logic            ev_set, ev_start, ev_inc, ack, tick, expire;

    assign ev_set   = key[1] & ~key_q[1];
    assign ev_start = key[2] & ~key_q[2];
    assign ev_inc   = key[3] & ~key_q[3];
    assign ack      = ev_set | ev_start | ev_inc;
    assign tick     = (st == RUN) && (pr == PT);
    // time reaches 00:00 after this tick's decrement
    assign expire   = (min_val == '0) && (sec_val <= 6'd1);
    assign state    = st;

    always_comb begin
        st_n  = st;
        min_n = min_val;
        sec_n = sec_val;
        pr_n  = pr;
        hc_n  = hc;
        pc_n  = pc;
        if (key[0]) begin
            st_n = SET_SEC; min_n = '0; sec_n = '0; pr_n = '0; hc_n = '0; pc_n = '0;
        end else begin
            case (st)
                SET_SEC: begin
                    if (ev_set)      st_n  = SET_MIN;
                    else if (ev_inc) sec_n = (sec_val == 6'd59) ? 6'd0 : sec_val + 6'd1;
                end
                SET_MIN: begin
                    if (ev_set)      st_n  = (min_val != '0 || sec_val != '0) ? READY : SET_SEC;
                    else if (ev_inc) min_n = (min_val == MM) ? '0 : min_val + MIN_W'(1);
                end
                READY: begin
                    if (ev_start) begin st_n = RUN; pr_n = '0; end
                    else if (ev_set) st_n = SET_SEC;
                end
                RUN: begin
                    if (tick) begin
                        pr_n = '0;
                        if (sec_val != '0) sec_n = sec_val - 6'd1;
                        else if (min_val != '0) begin
                            min_n = min_val - MIN_W'(1);
                            sec_n = 6'd59;
                        end
                        if (expire) begin st_n = FLASH_ON; hc_n = '0; pc_n = '0; end
                        else if (ev_start) st_n = PAUSE;
                    end else if (ev_start) st_n = PAUSE;
                    else pr_n = pr + PW'(1);
                end
                PAUSE: begin
                    if (ev_start)    st_n = RUN;
                    else if (ev_set) begin st_n = READY; pr_n = '0; end
                end
                FLASH_ON: begin
                    if (ack) begin
                        st_n = SET_SEC; min_n = '0; sec_n = '0; hc_n = '0; pc_n = '0;
                    end else if (hc == HT) begin
                        hc_n = '0; st_n = FLASH_OFF;
                    end else hc_n = hc + FW'(1);
                end
                FLASH_OFF: begin
                    if (ack) begin
                        st_n = SET_SEC; min_n = '0; sec_n = '0; hc_n = '0; pc_n = '0;
                    end else if (hc == HT) begin
                        hc_n = '0;
                        if (FLASH_COUNT > 0 && pc + CW'(1) == FC) begin
                            st_n = SET_SEC; min_n = '0; sec_n = '0; pc_n = '0;
                        end else begin
                            st_n = FLASH_ON; pc_n = pc + CW'(1);
                        end
                    end else hc_n = hc + FW'(1);
                end
                default: begin
                    st_n = SET_SEC; min_n = '0; sec_n = '0; pr_n = '0; hc_n = '0; pc_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= SET_SEC;
            min_val <= '0;
            sec_val <= '0;
            pr      <= '0;
            hc      <= '0;
            pc      <= '0;
            key_q   <= 3'b111;
            alarm   <= 1'b0;
            blank   <= 1'b0;
        end else begin
            st      <= st_n;
            min_val <= min_n;
            sec_val <= sec_n;
            pr      <= pr_n;
            hc      <= hc_n;
            pc      <= pc_n;
            key_q   <= key[3:1];
            alarm   <= (st_n == FLASH_ON) || (st_n == FLASH_OFF);
            blank   <= (st_n == FLASH_OFF);
        end
    end
endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed + randomized bench for egg_timer_ctrl against a time-in-seconds
// behavioural model with small parameters.
module tb_egg_timer_ctrl;
    localparam int TD = 4, MW = 4, MMAX = 9, FH = 3, FCNT = 2;

    logic          clk = 1'b0, reset = 1'b1;
    logic [3:0]    key = 4'b0000;
    logic [2:0]    state;
    logic [MW-1:0] min_val;
    logic [5:0]    sec_val;
    logic          alarm, blank;

    int tests = 0, fails = 0;
    // model: mode (display encoding), minutes, seconds, cycles into current
    // second, cycles since expiry, previous key levels
    int m_mode, m_min, m_sec, m_el, m_fl;
    logic [3:0] m_kq;

    egg_timer_ctrl #(.TICK_DIV(TD), .MIN_W(MW), .MIN_MAX(MMAX),
                     .FLASH_HALF(FH), .FLASH_COUNT(FCNT)) dut (
        .clk(clk), .reset(reset), .key(key), .state(state),
        .min_val(min_val), .sec_val(sec_val), .alarm(alarm), .blank(blank));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0; m_min = 0; m_sec = 0; m_el = 0; m_fl = 0; m_kq = 4'b1111;
    endtask

    task automatic m_clear();
        m_mode = 0; m_min = 0; m_sec = 0; m_el = 0; m_fl = 0;
    endtask

    task automatic m_step(input logic [3:0] k);
        logic [3:0] ev;
        int t;
        ev = k & ~m_kq;
        m_kq = k;
        if (k[0]) m_clear();
        else case (m_mode)
            0: if (ev[1]) m_mode = 1; else if (ev[3]) m_sec = (m_sec + 1) % 60;
            1: if (ev[1]) m_mode = (m_min + m_sec != 0) ? 3 : 0;
               else if (ev[3]) m_min = (m_min + 1) % (MMAX + 1);
            3: if (ev[2]) begin m_mode = 2; m_el = 0; end else if (ev[1]) m_mode = 0;
            2: if (m_el == TD - 1) begin
                   m_el = 0;
                   t = m_min * 60 + m_sec - 1;
                   m_min = t / 60; m_sec = t % 60;
                   if (t == 0) begin m_mode = 5; m_fl = 0; end
                   else if (ev[2]) m_mode = 7;
               end else if (ev[2]) m_mode = 7;
               else m_el++;
            7: if (ev[2]) m_mode = 2; else if (ev[1]) begin m_mode = 3; m_el = 0; end
            5, 6: if (ev[1] | ev[2] | ev[3]) m_clear();
                  else begin
                      m_fl++;
                      if (m_fl == 2 * FH * FCNT) m_clear();
                      else m_mode = ((m_fl / FH) % 2) ? 6 : 5;
                  end
            default: m_clear();
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, state, m_mode);
        chk({tag, ".min"}, min_val, m_min);
        chk({tag, ".sec"}, sec_val, m_sec);
        chk({tag, ".alarm"}, alarm, (m_mode == 5 || m_mode == 6));
        chk({tag, ".blank"}, blank, (m_mode == 6));
    endtask

    task automatic cyc(input logic [3:0] k, input string tag);
        key = k;
        @(posedge clk);
        m_step(k);
        #1;
        check_all(tag);
    endtask

    task automatic pulse(input logic [3:0] k, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc(k, tag);
            cyc(4'b0000, tag);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(4'b0000, tag);
    endtask

    // clear then program mm:ss and step into READY
    task automatic load(input int mm, input int ss, input string tag);
        cyc(4'b0001, tag);
        pulse(4'b1000, ss, tag);
        pulse(4'b0010, 1, tag);
        pulse(4'b1000, mm, tag);
        pulse(4'b0010, 1, tag);
    endtask

    initial begin
        // keys held through reset release produce no events
        key = 4'b1110;
        m_reset();
        #12;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(4'b1110, "hold");
        chk("hold.state0", state, 0);
        idle(2, "idle");

        // field wrap and navigation
        pulse(4'b1000, 61, "secinc");
        chk("secwrap", sec_val, 1);
        pulse(4'b0010, 1, "toset_min");
        chk("state_setmin", state, 1);
        pulse(4'b1000, 11, "mininc");
        chk("minwrap", min_val, 1);
        pulse(4'b0010, 1, "toready");
        chk("state_ready", state, 3);

        // READY refused at 00:00
        cyc(4'b0001, "clr");
        pulse(4'b0010, 2, "refuse");
        chk("refused", state, 0);

        // 00:02 countdown to expiry and full unacknowledged flash
        load(0, 2, "ld2");
        cyc(4'b0100, "start");
        idle(4, "run");
        chk("run.sec1", sec_val, 1);
        idle(4, "run");
        chk("exp.sec0", sec_val, 0);
        chk("exp.state5", state, 5);
        chk("exp.alarm", alarm, 1);
        idle(12, "flash");
        chk("flash.end", state, 0);
        chk("flash.alarm0", alarm, 0);

        // 01:00 borrow, pause/resume, start coincident with tick
        load(1, 0, "ld100");
        cyc(4'b0100, "start");
        idle(3, "run");
        cyc(4'b0000, "tick");
        chk("borrow.min", min_val, 0);
        chk("borrow.sec", sec_val, 59);
        idle(2, "run");
        cyc(4'b0100, "pause");
        chk("paused", state, 7);
        idle(20, "pausehold");
        chk("frozen", sec_val, 59);
        cyc(4'b0100, "resume");
        cyc(4'b0000, "resume1");
        chk("resume.not_yet", sec_val, 59);
        cyc(4'b0000, "resume2");
        chk("resume.dec", sec_val, 58);
        idle(3, "run");
        cyc(4'b0100, "tickpause");
        chk("tickpause.sec", sec_val, 57);
        chk("tickpause.state", state, 7);

        // acknowledge during FLASH_OFF
        load(0, 1, "ld1");
        cyc(4'b0100, "start");
        idle(4, "run");
        idle(3, "flash");
        chk("flashoff", state, 6);
        chk("flashoff.blank", blank, 1);
        cyc(4'b1000, "ack");
        chk("ack.state", state, 0);

        // clear beats a simultaneous start in RUN
        load(2, 5, "ld");
        cyc(4'b0100, "start");
        idle(5, "run");
        cyc(4'b0101, "clrwins");
        chk("clrwins.state", state, 0);
        chk("clrwins.sec", sec_val, 0);
        cyc(4'b0000, "post");

        // asynchronous reset mid-RUN
        load(3, 0, "ld");
        cyc(4'b0100, "start");
        idle(6, "run");
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_reset();
        check_all("asyncrst");
        @(negedge clk);
        reset = 1'b0;
        cyc(4'b0000, "postrst");

        // randomized key activity against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] k;
            k = key;
            if ($urandom_range(0, 3) == 0) k[3:1] = 3'($urandom);
            k[0] = ($urandom_range(0, 199) == 0);
            // bias toward loading time and starting so RUN/flash get exercised
            if ($urandom_range(0, 15) == 0) k[2] = 1'b1;
            cyc(k, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
